ifid_stage: RTL and testbench

- IF/ID pipeline stage. It is the consumer of the stall and flush enables produced by the pipeline hazard unit.
- Accepts fetch responses from the synchronous instruction memory, which returns data exactly one cycle after a request.
- Holds the stage on stall. Preserves the in-flight response in a one-entry skid register, squashes on flush, and replays the buffered instruction when the stall releases.
- Sits between the PC/imem fetch logic and the ID stage of the 5-stage core.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/ifid_skid.sv | 36 +++
 rtl/ifid_stage.sv | 137 +++++++++++++
 tb/tb_ifid_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: stage FSM states, the NOP encoding and the
// canonical 32-bit IF/ID entry seen by the ID stage.
package pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        REPLAY = 2'd2
    } ifid_state_e;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_skid.sv
// One-entry skid register: catches the fetch response that lands while the
// stage is held, so it can be replayed into IF/ID on release.
module ifid_skid #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          unload,
    input  logic          clear,
    input  logic [AW-1:0] load_pc,
    input  logic [DW-1:0] load_instr,
    output logic          valid,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] instr
);

    // clear (flush) dominates a same-cycle load
    always_ff @(posedge clk) begin
        if (rst || clear)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (unload)
            valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with stall hold, skid replay and flush squash.
// Optional IFID_STALL_STATS_EN adds saturating stall/flush counters.
module ifid_stage
    import pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
`ifdef IFID_STALL_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic          flush_in,
    output logic          fetch_req,
    input  logic [AW-1:0] pc_in,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          id_valid,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_instr,
    output logic          skid_busy
`ifdef IFID_STALL_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    ifid_state_e   state;
    logic [AW-1:0] pc_q;
    logic          req_q;
    logic          drop_q;
    logic          live;
    logic          skid_valid;
    logic [AW-1:0] skid_pc;
    logic [DW-1:0] skid_instr;
    logic          skid_load;
    logic          skid_unload;

    assign fetch_req   = ~rst & en_in & ~flush_in & (state == RUN);
    assign live        = imem_rvalid & ~drop_q;
    assign skid_load   = (state == RUN)  & ~flush_in & ~en_in & live;
    assign skid_unload = (state == HOLD) & ~flush_in & en_in & skid_valid;
    assign skid_busy   = skid_valid;

    ifid_skid #(.DW(DW), .AW(AW)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (flush_in),
        .load_pc    (pc_q),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= DW'(NOP_INSTR);
            pc_q     <= '0;
            req_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            req_q <= fetch_req;
            if (fetch_req)
                pc_q <= pc_in;
            if (imem_rvalid)
                drop_q <= 1'b0;

            if (flush_in) begin
                // A response landing in the flush cycle is discarded here;
                // drop_q only covers one that is still on its way.
                id_valid <= 1'b0;
                state    <= RUN;
                drop_q   <= (drop_q | req_q) & ~imem_rvalid;
            end else begin
                unique case (state)
                    RUN: begin
                        if (en_in) begin
                            id_valid <= live;
                            if (live) begin
                                id_pc    <= pc_q;
                                id_instr <= imem_rdata;
                            end
                        end else begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        // Release advances the held entry into ID, so IF/ID
                        // takes the skid contents or becomes a bubble.
                        if (en_in) begin
                            id_valid <= skid_valid;
                            if (skid_valid) begin
                                id_pc    <= skid_pc;
                                id_instr <= skid_instr;
                                state    <= REPLAY;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    REPLAY: begin
                        if (en_in) begin
                            id_valid <= 1'b0;
                            state    <= RUN;
                        end else begin
                            state <= HOLD;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

`ifdef IFID_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!en_in && !flush_in && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_in && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Self-checking bench for ifid_stage: directed scenarios plus an in-order
// scoreboard of instructions the ID stage is expected to consume.
module tb_ifid_stage;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CNT_W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_in;
    logic          flush_in;
    logic          fetch_req;
    logic [AW-1:0] pc_in;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          id_valid;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_instr;
    logic          skid_busy;
`ifdef IFID_STALL_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    ifid_entry_t exp_q[$];
    ifid_entry_t mon_e;

    ifid_stage dut (
        .clk         (clk),
        .rst         (rst),
        .en_in       (en_in),
        .flush_in    (flush_in),
        .fetch_req   (fetch_req),
        .pc_in       (pc_in),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .skid_busy   (skid_busy)
`ifdef IFID_STALL_STATS_EN
      , .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hAAAA_0001;
        return {8'h5A, a[23:0]};
    endfunction

    // Synchronous imem: data exactly one cycle after the request
    always @(posedge clk) begin
        imem_rvalid <= fetch_req;
        imem_rdata  <= mem_word(pc_in);
    end

    // ID consumes IF/ID whenever it holds a live entry and the stage advances
    always @(negedge clk) begin
        if (!rst && id_valid && en_in && !flush_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL consume: got pc=%h instr=%h, expected no instruction", id_pc, id_instr);
            end else begin
                mon_e = exp_q.pop_front();
                if (id_pc !== mon_e.pc || id_instr !== mon_e.instr) begin
                    errors++;
                    $display("FAIL consume: got pc=%h instr=%h, expected pc=%h instr=%h",
                             id_pc, id_instr, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    task automatic drive(input logic en, input logic fl, input logic [31:0] pc);
        en_in = en; flush_in = fl; pc_in = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_q.push_back('{valid: 1'b1, pc: pc, instr: mem_word(pc)});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0);
        tick(); tick();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rst_fetch_req: got %b expected 0", fetch_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h expected 0", id_pc); end
        checks++; if (id_instr !== NOP_INSTR) begin errors++; $display("FAIL rst_id_instr: got %h expected %h", id_instr, NOP_INSTR); end
        checks++; if (skid_busy !== 1'b0) begin errors++; $display("FAIL rst_skid_busy: got %b expected 0", skid_busy); end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0); exp_push(32'h0);
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL stream_req: got %b expected 1", fetch_req); end
        tick();
        drive(1'b1, 1'b0, 32'h4); exp_push(32'h4);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_early: got valid %b expected 0", id_valid); end
        tick();
        drive(1'b1, 1'b0, 32'h8); exp_push(32'h8);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== mem_word(32'h0)) begin
            errors++; $display("FAIL stream_lat: got %b/%h/%h expected 1/00000000/%h", id_valid, id_pc, id_instr, mem_word(32'h0));
        end
        tick();
    endtask

    task automatic test_stall_replay();
        drive(1'b1, 1'b0, 32'h10); exp_push(32'h10);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4) begin errors++; $display("FAIL stream_nobubble: got %b/%h expected 1/00000004", id_valid, id_pc); end
        tick();
        drive(1'b0, 1'b0, 32'h14);
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", fetch_req); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h14);
            checks++; if (skid_busy !== 1'b1) begin errors++; $display("FAIL stall_skid%0d: got %b expected 1", i, skid_busy); end
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin errors++; $display("FAIL stall_hold%0d: got %b/%h expected 1/00000008", i, id_valid, id_pc); end
            tick();
        end
        drive(1'b1, 1'b0, 32'h14);
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL release_req: got %b expected 0", fetch_req); end
        tick();
        drive(1'b1, 1'b0, 32'h14);
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL replay_req: got %b expected 0", fetch_req); end
        checks++; if (id_pc !== 32'h10 || id_instr !== 32'hAAAA_0001) begin errors++; $display("FAIL replay_data: got %h/%h expected 00000010/aaaa0001", id_pc, id_instr); end
        checks++; if (skid_busy !== 1'b0) begin errors++; $display("FAIL replay_skid: got %b expected 0", skid_busy); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 32'h20);
        checks++; if (fetch_req !== 1'b1 || id_valid !== 1'b0) begin errors++; $display("FAIL post_replay: got req %b valid %b expected 1/0", fetch_req, id_valid); end
        tick();
        drive(1'b1, 1'b1, 32'h40);
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL flush_req: got %b expected 0", fetch_req); end
        tick();
        drive(1'b1, 1'b0, 32'h40); exp_push(32'h40);
        checks++; if (id_valid !== 1'b0 || fetch_req !== 1'b1) begin errors++; $display("FAIL flush_after: got valid %b req %b expected 0/1", id_valid, fetch_req); end
        tick();
        drive(1'b1, 1'b0, 32'h44);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got valid %b pc %h expected 0", id_valid, id_pc); end
        tick();
        drive(1'b1, 1'b0, 32'h48);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin errors++; $display("FAIL flush_newpc: got %b/%h expected 1/00000040", id_valid, id_pc); end
        tick();
    endtask

    task automatic test_flush_stall();
        drive(1'b0, 1'b0, 32'h4C);
        tick();
        drive(1'b0, 1'b1, 32'h4C);
        checks++; if (skid_busy !== 1'b1) begin errors++; $display("FAIL fs_pre: got skid %b expected 1", skid_busy); end
        tick();
        drive(1'b1, 1'b0, 32'h60);
        checks++; if (skid_busy !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL fs_empty: got skid %b valid %b expected 0/0", skid_busy, id_valid); end
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL fs_run: got req %b expected 1", fetch_req); end
        tick();
    endtask

    task automatic test_reset_hold();
        drive(1'b1, 1'b0, 32'h64);
        tick();
        drive(1'b0, 1'b0, 32'h68);
        tick();
        drive(1'b0, 1'b0, 32'h68);
        checks++; if (skid_busy !== 1'b1) begin errors++; $display("FAIL rh_pre: got skid %b expected 1", skid_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h68);
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== NOP_INSTR || skid_busy !== 1'b0) begin
            errors++; $display("FAIL rh_reset: got %b/%h/%h skid %b expected 0/00000000/00000000 skid 0", id_valid, id_pc, id_instr, skid_busy);
        end
        tick();
        drive(1'b1, 1'b0, 32'h80);
        checks++; if (fetch_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL rh_release: got req %b valid %b expected 0/0", fetch_req, id_valid); end
        tick();
        drive(1'b1, 1'b0, 32'h80); exp_push(32'h80);
        checks++; if (fetch_req !== 1'b1 || id_valid !== 1'b0) begin errors++; $display("FAIL rh_noreplay: got req %b valid %b expected 1/0", fetch_req, id_valid); end
        tick();
        drive(1'b1, 1'b0, 32'h84); exp_push(32'h84);
        tick();
        drive(1'b1, 1'b0, 32'h88);
        checks++; if (id_pc !== 32'h80) begin errors++; $display("FAIL rh_first: got pc %h expected 00000080", id_pc); end
        tick();
        drive(1'b1, 1'b0, 32'h8C);
        tick();
        drive(1'b1, 1'b1, 32'h90);
        tick();
        drive(1'b0, 1'b0, 32'h90);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL end_valid: got %b expected 0", id_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size()); end
        tick();
    endtask

`ifdef IFID_STALL_STATS_EN
    task automatic test_stats();
        rst = 1'b1; drive(1'b0, 1'b0, 32'h0); tick();
        rst = 1'b0;
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL st_rst: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 32'h0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 32'h0); tick(); end
        drive(1'b1, 1'b0, 32'h0);
        checks++; if (stall_cnt !== CNT_W'(5)) begin errors++; $display("FAIL st_stall: got %0d expected 5", stall_cnt); end
        checks++; if (flush_cnt !== CNT_W'(2)) begin errors++; $display("FAIL st_flush: got %0d expected 2", flush_cnt); end
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin drive(1'b0, 1'b0, 32'h0); tick(); end
        checks++; if (stall_cnt !== {CNT_W{1'b1}}) begin errors++; $display("FAIL st_sat: got %h expected all ones", stall_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; en_in = 1'b0; flush_in = 1'b0; pc_in = '0;
        test_reset();
        test_stream();
        test_stall_replay();
        test_flush();
        test_flush_stall();
        test_reset_hold();
`ifdef IFID_STALL_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
